// File: rtl/d_latch_rst.sv
// Transparent-high D latch with async active-low clear; WIDTH independent bits.
// Zero-cycle latency while open (q follows d), holds while clock low; no backpressure.
module d_latch_rst #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             rb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH-1:0] lat_q;

  // Clear wins over transparency; with clock low and rb high the cell holds.
  always_latch begin
    if (!rb) begin
      lat_q <= RESET_VAL;
    end else if (clock) begin
      lat_q <= d;
    end
  end

  assign q   = lat_q;
  assign q_n = ~lat_q;

endmodule

// File: tb/tb_d_latch_rst.sv
// Directed and randomized checks of d_latch_rst, single-bit, 8-bit and as a master-slave pair.
module tb_d_latch_rst;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk, rb, d1, q1, qn1;
  logic [7:0] d8, q8, qn8;
  logic       ms_clk, ms_rb, ms_d, a_q, a_qn, b_q, b_qn;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic       m1;
  logic [7:0] m8;

  d_latch_rst #(.WIDTH(1)) dut1 (
    .clock(clk), .rb(rb), .d(d1), .q(q1), .q_n(qn1)
  );

  d_latch_rst #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clock(clk), .rb(rb), .d(d8), .q(q8), .q_n(qn8)
  );

  d_latch_rst u_master (
    .clock(ms_clk), .rb(ms_rb), .d(ms_d), .q(a_q), .q_n(a_qn)
  );

  d_latch_rst u_slave (
    .clock(~ms_clk), .rb(ms_rb), .d(a_q), .q(b_q), .q_n(b_qn)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the cell shows the d seen during the latest open window since
  // the latest clear, or the reset value if it has not opened since then.
  task automatic drive(input logic c, input logic r, input logic dv1, input logic [7:0] dv8);
    clk = c;
    rb  = r;
    d1  = dv1;
    d8  = dv8;
    if (!r) begin
      m1 = 1'b0;
      m8 = RV8;
    end else if (c) begin
      m1 = dv1;
      m8 = dv8;
    end
    #1;
    check("q1",  {7'b0, q1},  {7'b0, m1});
    check("qn1", {7'b0, qn1}, {7'b0, ~m1});
    check("q8",  q8,  m8);
    check("qn8", qn8, ~m8);
  endtask

  initial begin
    logic       c, dd, r;
    logic       prev_c, last_d, eb;
    logic [7:0] rv8;

    clk = 1'b0; rb = 1'b0; d1 = 1'b0; d8 = 8'h00;
    ms_clk = 1'b0; ms_rb = 1'b0; ms_d = 1'b0;
    m1 = 1'b0; m8 = RV8;

    // Reset dominance: clock and d toggle while rb is held low.
    for (int t = 0; t <= 500; t += 50) begin
      c  = ((t / 100) % 2) == 1;
      dd = ((t / 150) % 2) == 1;
      drive(c, 1'b0, dd, {8{dd}});
      check("rst_dom_q",  {7'b0, q1},  8'h00);
      check("rst_dom_qn", {7'b0, qn1}, 8'h01);
      #49;
    end

    // Transparency: q tracks d within the same step.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, i[0], 8'h10 + 8'(i));
      #9;
    end

    // Hold: capture at falling clock, ignore d until clock rises again.
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    #99;
    drive(1'b0, 1'b1, 1'b1, 8'h77);
    #49;
    drive(1'b0, 1'b1, 1'b0, 8'h11);
    check("hold_q", {7'b0, q1}, 8'h01);
    check("hold_q8", q8, 8'h77);
    #49;
    drive(1'b1, 1'b1, 1'b0, 8'h11);
    check("reopen_q", {7'b0, q1}, 8'h00);

    // Wide reset value, then release while open.
    drive(1'b1, 1'b0, 1'b1, 8'h3C);
    check("wide_rst_q",  q8,  8'hA5);
    check("wide_rst_qn", qn8, 8'h5A);
    drive(1'b1, 1'b1, 1'b1, 8'h3C);
    check("rel_open_q1", {7'b0, q1}, 8'h01);
    check("wide_rel_q",  q8,  8'h3C);
    check("wide_rel_qn", qn8, 8'hC3);

    // Release while closed: reset value persists until clock rises.
    drive(1'b0, 1'b0, 1'b1, 8'h3C);
    drive(1'b0, 1'b1, 1'b1, 8'h3C);
    rv8 = q8;
    check("rel_closed_q1", {7'b0, q1}, 8'h00);
    check("rel_closed_q8", rv8, 8'hA5);
    #10;
    drive(1'b1, 1'b1, 1'b1, 8'h3C);
    check("rel_closed_open_q1", {7'b0, q1}, 8'h01);

    // Reset during transparent phase, then resume following d.
    drive(1'b1, 1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 1'b0, 8'h5E);
    drive(1'b1, 1'b1, 1'b1, 8'h9B);

    // Randomized sequences.
    for (int i = 0; i < 60; i++) begin
      c = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 7) != 0);
      drive(c, r, 1'($urandom_range(0, 1)), 8'($urandom));
      #4;
    end

    // Master-slave pair: slave updates only on falling clock, with the d
    // present just before the fall; clear forces zero.
    prev_c = 1'b0;
    last_d = 1'b0;
    eb     = 1'b0;
    for (int t = 0; t <= 800; t += 50) begin
      c  = ((t / 100) % 2) == 0;
      r  = (t >= 200) && (t < 700);
      dd = ((t / 150) % 2) == 1;
      ms_clk = c;
      ms_rb  = r;
      if (!r)
        eb = 1'b0;
      else if (prev_c && !c)
        eb = last_d;
      #1;
      ms_d = dd;
      #1;
      check("ms_q",  {7'b0, b_q},  {7'b0, eb});
      check("ms_qn", {7'b0, b_qn}, {7'b0, ~eb});
      prev_c = c;
      last_d = dd;
      #48;
    end
    check("ms_final_q", {7'b0, b_q}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
